// File: rtl/jpeg_drain_master.sv
// jpeg_drain_master
// Drains compressed data from a JPEG encoder peripheral over a simple
// request/grant read bus and presents it as a 32-bit stream with a
// valid-bit count on the final beat.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   en                         : allow new drain sequences to start
//   fifo_irq, end_irq, err_irq : encoder FIFO level, end-of-stream pulse,
//                                FIFO-full error
//   req/add/wen/wdata/be/id    : bus request (reads only)
//   gnt/r_valid/r_rdata/r_id   : bus grant and read response
//   m_valid/m_ready/m_data/
//   m_last/m_bits              : output stream, m_bits = valid bits (1..32)
//   busy, done, error          : status (done is a 1-cycle pulse, error sticky)
module jpeg_drain_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned TXN_ID    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                fifo_irq,
  input  logic                end_irq,
  input  logic                err_irq,
  output logic                req,
  output logic [31:0]         add,
  output logic                wen,
  output logic [31:0]         wdata,
  output logic [3:0]          be,
  output logic [ID_WIDTH-1:0] id,
  input  logic                gnt,
  input  logic                r_valid,
  input  logic [31:0]         r_rdata,
  input  logic [ID_WIDTH-1:0] r_id,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [31:0]         m_data,
  output logic                m_last,
  output logic [5:0]          m_bits,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_REQ_DEPTH  = 3'd1;
  localparam logic [2:0] S_WAIT_DEPTH = 3'd2;
  localparam logic [2:0] S_REQ_DATA   = 3'd3;
  localparam logic [2:0] S_WAIT_DATA  = 3'd4;
  localparam logic [2:0] S_REQ_END    = 3'd5;
  localparam logic [2:0] S_WAIT_END   = 3'd6;
  localparam logic [2:0] S_FLUSH      = 3'd7;

  localparam logic [31:0] ADDR_DATA  = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_DEPTH = BASE_ADDR + 32'h0000_0200;
  localparam logic [31:0] ADDR_END   = BASE_ADDR + 32'h0000_0300;
  localparam logic [ID_WIDTH-1:0] TXN_ID_W = ID_WIDTH'(TXN_ID);

  logic [2:0]  state_r;
  logic [5:0]  remain_r;
  logic        end_pend_r;
  logic [4:0]  eb_r;
  logic [31:0] held_r;
  logic        held_valid_r;
  logic        req_r;
  logic [31:0] add_r;
  logic        done_r;
  logic        error_r;

  // two-entry output buffer
  logic [31:0] data_mem_r [2];
  logic        last_mem_r [2];
  logic [5:0]  bits_mem_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;

  logic        rsp_ok_s;
  logic        push_s;
  logic        pop_s;
  logic        push_last_s;
  logic [5:0]  push_bits_s;
  logic        room_s;

  assign rsp_ok_s = r_valid && (r_id == TXN_ID_W);
  assign pop_s    = m_valid && m_ready;
  assign room_s   = (count_r != 2'd2);

  // Select what (if anything) enters the output buffer this cycle.
  always_comb begin
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_bits_s = 6'd32;
    if (state_r == S_WAIT_DATA && rsp_ok_s && held_valid_r) begin
      // a newer word arrived, so the held one is known not to be last
      push_s = 1'b1;
    end else if (state_r == S_FLUSH && held_valid_r && room_s) begin
      push_s      = 1'b1;
      push_last_s = 1'b1;
      push_bits_s = (eb_r == 5'd0) ? 6'd32 : {1'b0, eb_r};
    end else begin
      push_s = 1'b0;
    end
  end

  // Drain sequencer, bus request registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      remain_r     <= 6'd0;
      end_pend_r   <= 1'b0;
      eb_r         <= 5'd0;
      held_r       <= 32'd0;
      held_valid_r <= 1'b0;
      req_r        <= 1'b0;
      add_r        <= BASE_ADDR;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (err_irq) begin
        error_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (en && (fifo_irq || end_pend_r)) begin
            state_r <= S_REQ_DEPTH;
            req_r   <= 1'b1;
            add_r   <= ADDR_DEPTH;
          end
        end
        S_REQ_DEPTH: begin
          if (gnt) begin
            req_r   <= 1'b0;
            state_r <= S_WAIT_DEPTH;
          end
        end
        S_WAIT_DEPTH: begin
          if (rsp_ok_s) begin
            remain_r <= r_rdata[5:0];
            if (r_rdata[5:0] != 6'd0) begin
              state_r <= S_REQ_DATA;
            end else if (end_pend_r) begin
              state_r <= S_REQ_END;
              req_r   <= 1'b1;
              add_r   <= ADDR_END;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        S_REQ_DATA: begin
          // only ask for a word when the buffer is guaranteed to have room
          // for the held word it will displace
          if (!req_r) begin
            if (room_s) begin
              req_r <= 1'b1;
              add_r <= ADDR_DATA;
            end
          end else if (gnt) begin
            req_r   <= 1'b0;
            state_r <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (rsp_ok_s) begin
            held_r       <= r_rdata;
            held_valid_r <= 1'b1;
            remain_r     <= remain_r - 6'd1;
            if (remain_r == 6'd1) begin
              state_r <= S_REQ_DEPTH;
              req_r   <= 1'b1;
              add_r   <= ADDR_DEPTH;
            end else begin
              state_r <= S_REQ_DATA;
            end
          end
        end
        S_REQ_END: begin
          if (gnt) begin
            req_r   <= 1'b0;
            state_r <= S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (rsp_ok_s) begin
            eb_r       <= r_rdata[4:0];
            end_pend_r <= 1'b0;
            state_r    <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (held_valid_r) begin
            if (room_s) begin
              held_valid_r <= 1'b0;
            end
          end else if (count_r == 2'd0) begin
            // buffer empty: the last beat (if any) has been handed over
            done_r  <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          req_r   <= 1'b0;
        end
      endcase
      // a fresh end pulse wins over the clear on entry to FLUSH
      if (end_irq) begin
        end_pend_r <= 1'b1;
      end
    end
  end

  // Output buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_mem_r[i] <= 32'd0;
        last_mem_r[i] <= 1'b0;
        bits_mem_r[i] <= 6'd0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= held_r;
        last_mem_r[wr_ptr_r] <= push_last_s;
        bits_mem_r[wr_ptr_r] <= push_bits_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign req     = req_r;
  assign add     = add_r;
  assign wen     = 1'b1;
  assign wdata   = 32'd0;
  assign be      = 4'hF;
  assign id      = TXN_ID_W;
  assign m_valid = (count_r != 2'd0);
  assign m_data  = data_mem_r[rd_ptr_r];
  assign m_last  = last_mem_r[rd_ptr_r];
  assign m_bits  = bits_mem_r[rd_ptr_r];
  assign busy    = (state_r != S_IDLE) || m_valid;
  assign done    = done_r;
  assign error   = error_r;

endmodule

// File: tb/tb_jpeg_drain_master.sv
module tb_jpeg_drain_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int IDW = 4;
  localparam int TID = 5;
  localparam int K_DATA  = 0;
  localparam int K_DEPTH = 1;
  localparam int K_END   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, fifo_irq = 1'b0, end_irq = 1'b0, err_irq = 1'b0;
  logic req, wen;
  logic [31:0] add, wdata;
  logic [3:0] be;
  logic [IDW-1:0] id;
  logic gnt = 1'b0, r_valid = 1'b0;
  logic [31:0] r_rdata = 32'd0;
  logic [IDW-1:0] r_id = '0;
  logic m_valid, m_last, busy, done, error;
  logic m_ready = 1'b0;
  logic [31:0] m_data;
  logic [5:0] m_bits;

  always #5 clk = ~clk;

  jpeg_drain_master #(.BASE_ADDR(BASE), .ID_WIDTH(IDW), .TXN_ID(TID)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_irq(fifo_irq), .end_irq(end_irq),
    .err_irq(err_irq), .req(req), .add(add), .wen(wen), .wdata(wdata), .be(be),
    .id(id), .gnt(gnt), .r_valid(r_valid), .r_rdata(r_rdata), .r_id(r_id),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_bits(m_bits), .busy(busy), .done(done), .error(error));

  // expected beat: {data, last, bits}
  logic [38:0] exp_q[$];
  int errors = 0, checks = 0;

  // reference model / bus slave state
  int depth_q[$];
  int eb_q[$];
  bit resp_pending = 0;
  int resp_delay = 0;
  int resp_kind = 0;
  logic [31:0] resp_data = 32'd0;
  bit have_held = 0;
  logic [31:0] held = 32'd0;
  int done_exp = 0, done_seen = 0;
  int last_depth = 0;
  int model_pushes = 0, pops = 0;
  int data_grants = 0;
  bit hold_data = 0, stale_go = 0, stall_force = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // bus slave plus reference model: answers reads from scripted queues
  initial begin : slave
    bit prev_req;
    bit stale_done;
    logic [31:0] prev_add;
    logic [31:0] off;
    prev_req = 0;
    stale_done = 0;
    prev_add = 32'd0;
    forever begin
      @(posedge clk); #1;
      gnt = 1'b0; r_valid = 1'b0; r_id = IDW'(TID);
      if (!rst_n) begin
        resp_pending = 0;
        exp_q.delete();
        have_held = 0;
        model_pushes = pops;
        prev_req = 0;
      end else begin
        if (prev_req && req) check("add_stable", add, prev_add);
        if (stale_go && !stale_done) begin
          r_valid = 1'b1; r_rdata = $urandom; stale_done = 1;
        end else if (resp_pending) begin
          if (resp_delay > 0) begin
            resp_delay--;
            if ($urandom_range(0, 2) == 0) begin
              r_valid = 1'b1; r_id = IDW'(TID + 1); r_rdata = $urandom;
            end
          end else if (!(hold_data && resp_kind == K_DATA)) begin
            r_valid = 1'b1; r_rdata = resp_data; resp_pending = 0;
            if (resp_kind == K_DEPTH) begin
              last_depth = int'(resp_data);
            end else if (resp_kind == K_DATA) begin
              if (have_held) begin
                exp_q.push_back({held, 1'b0, 6'd32});
                model_pushes++;
              end
              held = resp_data; have_held = 1;
            end else begin
              if (have_held) begin
                exp_q.push_back({held, 1'b1, (resp_data[4:0] == 5'd0) ? 6'd32 : {1'b0, resp_data[4:0]}});
                model_pushes++;
              end
              have_held = 0;
              done_exp++;
            end
          end
        end else if (req) begin
          if ($urandom_range(0, 2) != 0) begin
            gnt = 1'b1;
            check("req_fields", {wen, be, wdata, id}, {1'b1, 4'hF, 32'd0, 4'(TID)});
            off = add - BASE;
            resp_pending = 1;
            resp_delay = $urandom_range(0, 3);
            if (off == 32'h0000_0000) begin
              resp_kind = K_DATA; resp_data = $urandom; data_grants++;
              check("data_issue_room", 64'((model_pushes - pops) < 2), 64'd1);
            end else if (off == 32'h0000_0200) begin
              resp_kind = K_DEPTH;
              resp_data = (depth_q.size() > 0) ? 32'(depth_q.pop_front()) : 32'd0;
            end else begin
              check("bus_addr_valid", off, 32'h0000_0300);
              resp_kind = K_END;
              check("end_after_zero_depth", 64'(last_depth), 64'd0);
              resp_data = (eb_q.size() > 0) ? 32'(eb_q.pop_front()) : 32'd0;
            end
          end
        end else if ($urandom_range(0, 7) == 0) begin
          r_valid = 1'b1; r_id = IDW'(TID + 1); r_rdata = $urandom;
        end
        prev_req = req && !gnt;
        prev_add = add;
      end
    end
  end

  // stream sink ready pattern
  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      m_ready = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: pops the scoreboard whenever a beat is handed over
  initial begin : monitor
    bit stall_prev;
    logic [39:0] stall_val;
    logic [38:0] b;
    stall_prev = 0;
    stall_val = 40'd0;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if (rst_n) begin
        if (stall_prev) check("hold_stable", {m_valid, m_data, m_last, m_bits}, stall_val);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data=%0h last=%0d bits=%0d expected no beat", m_data, m_last, m_bits);
          end else begin
            b = exp_q.pop_front();
            check("beat", {m_data, m_last, m_bits}, b);
          end
          pops++;
        end
        stall_prev = m_valid && !m_ready;
        stall_val = {1'b1, m_data, m_last, m_bits};
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic pulse_fifo();
    @(posedge clk); #1; fifo_irq = 1'b1;
    @(posedge clk); #1; fifo_irq = 1'b0;
  endtask

  task automatic pulse_end();
    @(posedge clk); #1; end_irq = 1'b1;
    @(posedge clk); #1; end_irq = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (!busy && !req && !resp_pending) quiet++;
      else quiet = 0;
    end
    check({name, "_idle"}, 64'(quiet >= 4), 64'd1);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_done"}, 64'(done_seen), 64'(done_exp));
  endtask

  initial begin : main
    int pops0, bad, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {req, m_valid, m_last, done, error, busy}, 6'b0);
    check("rst_add", add, BASE);
    @(posedge clk); #3; rst_n = 1'b1; en = 1'b1;

    // three words, re-poll returns 0, no end: A and B out, C held
    depth_q.push_back(3);
    pulse_fifo();
    wait_idle("three_words");
    check("three_words_beats", 64'(pops), 64'd2);

    // end pulse flushes C with 13 valid bits
    eb_q.push_back(13);
    pulse_end();
    wait_idle("flush_13");
    check("flush_13_beats", 64'(pops), 64'd3);

    // ENDBITS of 0 means a full final word
    depth_q.push_back(2);
    pulse_fifo();
    wait_idle("two_words");
    eb_q.push_back(0);
    pulse_end();
    wait_idle("flush_0");

    // end with nothing held: no beat, done still pulses
    pops0 = pops;
    eb_q.push_back(7);
    pulse_end();
    wait_idle("empty_end");
    check("empty_end_no_beat", 64'(pops - pops0), 64'd0);

    // sink stalled during a 5-word burst
    t = data_grants;
    stall_force = 1;
    depth_q.push_back(5);
    pulse_fifo();
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("stall_data_reads", 64'(data_grants - t), 64'd3);
    check("stall_buffered_le2", 64'((model_pushes - pops) <= 2), 64'd1);
    stall_force = 0;
    wait_idle("stall");
    eb_q.push_back(9);
    pulse_end();
    wait_idle("stall_flush");

    // en low: no sequence starts
    @(posedge clk); #1; en = 1'b0; fifo_irq = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req || busy) bad = 1;
    end
    check("en_low_no_start", 64'(bad), 64'd0);
    @(posedge clk); #1; fifo_irq = 1'b0; en = 1'b1;

    // error is sticky and draining continues
    @(posedge clk); #1; err_irq = 1'b1;
    @(posedge clk); #1; err_irq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("error_set", 64'(error), 64'd1);

    // randomized bursts with end pulses landing mid-burst
    for (int r = 0; r < 6; r++) begin
      depth_q.push_back($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) depth_q.push_back($urandom_range(1, 3));
      pulse_fifo();
      if (r % 2 == 0 || $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        eb_q.push_back($urandom_range(0, 31));
        pulse_end();
      end
      wait_idle("random");
    end
    eb_q.push_back($urandom_range(0, 31));
    pulse_end();
    wait_idle("random_flush");
    check("error_sticky", 64'(error), 64'd1);

    // reset while waiting for a DATA response, then a stale response
    hold_data = 1;
    depth_q.push_back(3);
    pulse_fifo();
    t = data_grants;
    bad = 1;
    for (int i = 0; i < 300 && bad == 1; i++) begin
      @(negedge clk);
      if (data_grants != t) bad = 0;
    end
    check("reach_wait_data", 64'(bad), 64'd0);
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {req, m_valid, m_last, done, error, busy}, 6'b0);
    check("midrst_add", add, BASE);
    @(posedge clk); #3; rst_n = 1'b1; hold_data = 0; stale_go = 1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (req || busy || m_valid || done) bad = 1;
    end
    check("stale_ignored", 64'(bad), 64'd0);

    // block resumes from IDLE
    depth_q.push_back(1);
    pulse_fifo();
    wait_idle("resume");
    eb_q.push_back(20);
    pulse_end();
    wait_idle("resume_flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_drain_master.md
JPEG_DRAIN_MASTER -- requirements
Module: jpeg_drain_master

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000: bus byte address of the encoder peripheral; bits [9:8] select the register.
REQ-002 Parameter ID_WIDTH, 4: width of the bus transaction id.
REQ-003 Parameter TXN_ID, 0: constant id driven on every request.
REQ-004 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port en, input, 1: enables draining; when low, no new read sequence starts.
REQ-007 Ports fifo_irq and end_irq, input, 1 each: encoder FIFO-level interrupt (level) and end-of-stream interrupt (1-cycle pulse).
REQ-008 Port err_irq, input, 1: encoder FIFO-full error.
REQ-009 Bus request ports, outputs: req (1), add (32), wen (1, always 1 = read), wdata (32, always 0), be (4, always 4'hF), id (ID_WIDTH).
REQ-010 Bus response ports, inputs: gnt (1), r_valid (1), r_rdata (32), r_id (ID_WIDTH).
REQ-011 Stream output ports: m_valid (out, 1), m_ready (in, 1), m_data (out, 32), m_last (out, 1), m_bits (out, 6): valid bits in the beat, 1..32.
REQ-012 Status output ports: busy (1), done (1, single-cycle pulse), error (1, sticky).

Function
REQ-013 At most one bus read is outstanding; req holds with stable add until gnt, then deasserts for that transaction.
REQ-014 A response is accepted only when r_valid=1 and r_id==TXN_ID; any other response is ignored.
REQ-015 Register offsets: DATA = BASE_ADDR + 0x000; DEPTH = BASE_ADDR + 0x200; ENDBITS = BASE_ADDR + 0x300.
REQ-016 FSM states: IDLE, REQ_DEPTH, WAIT_DEPTH, REQ_DATA, WAIT_DATA, REQ_END, WAIT_END, FLUSH.
REQ-017 end_pend is set by end_irq in any state and cleared on entry to FLUSH.
REQ-018 IDLE goes to REQ_DEPTH when en=1 and (fifo_irq=1 or end_pend=1).
REQ-019 WAIT_DEPTH loads remain = r_rdata[5:0].
REQ-020 After WAIT_DEPTH: remain>0 goes to REQ_DATA; remain=0 with end_pend goes to REQ_END; remain=0 without end_pend goes to IDLE.
REQ-021 REQ_DATA issues a DATA read only when the output buffer can accept a word (no backpressure overflow).
REQ-022 WAIT_DATA decrements remain; at 0 it goes to REQ_DEPTH (re-poll), otherwise to REQ_DATA.
REQ-023 Holding register: each DATA word is held one step; on arrival of the next DATA word, the held word is emitted with m_last=0 and m_bits=32.
REQ-024 WAIT_END latches eb = r_rdata[4:0] and goes to FLUSH.
REQ-025 In FLUSH, if a held word exists, it is emitted with m_last=1 and m_bits = (eb==0 ? 32 : eb); with no held word, nothing is emitted.
REQ-026 FLUSH goes to IDLE after the last beat handshake (or immediately if nothing was emitted), pulsing done for 1 cycle.
REQ-027 Output buffer: 2-entry FIFO; a beat transfers when m_valid and m_ready; m_data, m_last and m_bits are stable while m_valid=1 and m_ready=0.
REQ-028 A simultaneous push and pop on a full buffer is legal; the occupancy is unchanged.
REQ-029 en deassertion mid-sequence: the current sequence completes through IDLE or FLUSH; no new sequence starts.
REQ-030 end_irq arriving during a data burst is retained; the ENDBITS read happens only after a DEPTH read returns 0.
REQ-031 err_irq=1 sets error, which clears only on reset; draining continues.
REQ-032 busy = (state != IDLE) or m_valid.

Reset
REQ-033 rst_n=0 asynchronously forces: state IDLE; req, m_valid, m_last, done, error and busy all 0; remain, end_pend, held-valid and buffer occupancy 0; add = BASE_ADDR.
REQ-034 Reset asserted mid-transaction discards any in-flight response; after release, the block resumes from IDLE only.

Verification
REQ-035 fifo_irq=1, DEPTH returns 3, DATA returns A,B,C, then DEPTH returns 0, no end -> beats A and B with last=0 and bits=32; C stays held; returns to IDLE.
REQ-036 Continue REQ-035: end_irq pulse, DEPTH returns 0, ENDBITS returns 13 -> beat C with last=1 and bits=13, done pulses once.
REQ-037 ENDBITS returns 0 -> final beat has bits=32.
REQ-038 end_irq with no data ever read -> DEPTH, then ENDBITS reads, no beat, done pulses.
REQ-039 m_ready=0 for 20 cycles during a 5-word burst -> at most 2 beats buffered, no DATA read issued while full, no data lost or reordered.
REQ-040 rst_n low for 1 cycle while WAIT_DATA, then a stale r_valid -> ignored; all outputs at reset values.
